id2ex_pipe_reg: RTL and testbench
=================================

# id2ex_pipe_reg

Parametrised ID→EX pipeline register with valid/ready flow control, flush-to-bubble and a saturating stall counter. It replaces the free-running ID/EX latch so that decode can be back-pressured by a multi-cycle EX and squashed on branch mispredict. It sits between the decode/register-read stage and the execute stage. An optional skid slot registers the upstream ready path.

## Interface
Parameters:
- DATA_W, 32, width of rs_data, rt_data, imm
- REG_ADDR_W, 5, width of rd
- OP_W, 6, width of opcode
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  squash all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- opcode_in, rs_data_in, rt_data_in, rd_in, imm_in  in  OP_W/DATA_W/DATA_W/REG_ADDR_W/DATA_W  decode payload
- out_valid  out  1  payload to EX is valid
- out_ready  in  1  EX consumes the beat this cycle
- opcode_out, rs_data_out, rt_data_out, rd_out, imm_out  out  same widths  registered payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- States: EMPTY (no beat), FULL (main register holds beat), SKID (main and skid both hold beats; skid build only).
- EMPTY: accept → FULL, main ← input.
- FULL: accept & out_ready → FULL, main ← input. Accept & !out_ready → SKID, skid ← input. No accept & out_ready → EMPTY. Otherwise hold.
- SKID: in_ready=0. out_ready → FULL, main ← skid. Otherwise hold.
- Outputs are always driven from the main register. out_valid = (state != EMPTY).
- flush=1 overrides every other input: next state EMPTY and the input beat is dropped. Payload registers keep their old values (don't-care while out_valid=0).
- stall_cnt increments when out_valid & !out_ready and saturates at 2^CNT_W−1. Only reset clears it; flush does not.
- Reset (reset=0 at edge): state EMPTY, out_valid=0, all payload outputs 0, skid payload 0, stall_cnt 0. in_ready reads 1 from the first cycle after reset.

## Timing
- Latency: a beat accepted at edge N appears on the outputs with out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- Payload must remain stable while out_valid & !out_ready (AXI-style; no retraction).
- Reset or flush asserted mid-stall discards every held beat in the same edge.
- Flush and an accept in the same cycle: the beat is dropped and the stage is empty afterwards.
- stall_cnt updates one cycle after the stall cycle it counts.

## Configuration
- ID2EX_SKID_EN defined:
  - Skid slot present.
  - in_ready = (state != SKID), a pure register output with no combinational path from out_ready.
  - Full throughput is maintained under back-pressure.
- Undefined:
  - No skid slot and no SKID state.
  - in_ready = !out_valid | out_ready, combinational from out_ready.
  - FULL with accept & !out_ready cannot occur.

## Structure
- Shared package id2ex_pkg:
  - id2ex_payload_t struct (opcode, rs_data, rt_data, rd, imm) built from the parameter defaults.
  - pipe_state_e enum (EMPTY, FULL, SKID).
  - Default width constants.
- One sub-module, pipe_skid_buf: generic over payload width, holds the state machine and the main/skid registers. id2ex_pipe_reg packs and unpacks the payload and owns stall_cnt.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 and arbitrary data → out_valid=0, all payload outputs 0, stall_cnt=0. First cycle after release: in_ready=1.
- Streaming: out_ready=1, send opcode 0x23, 0x2B, 0x04 on consecutive cycles → they appear on opcode_out one cycle later, back-to-back, with no loss and no duplication.
- Back-pressure (SKID_EN):
  - Fill FULL with beat A, drop out_ready, present beat B → state SKID, in_ready=0, A is held.
  - Raise out_ready → A then B delivered in order.
  - stall_cnt equals the number of stalled cycles.
- Flush: in SKID with A and B held plus C presented, assert flush for 1 cycle → next cycle out_valid=0. A, B and C are never delivered. stall_cnt is retained.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 15.
- Without SKID_EN: with FULL and out_ready=0, in_ready=0 in the same cycle. Toggling out_ready=1 raises in_ready combinationally, and a beat is accepted that cycle.

Source files
------------

// File: rtl/id2ex_pkg.sv
// Shared types and default widths for the ID->EX pipeline register.
// Build option: define ID2EX_SKID_EN to add the skid slot (see pipe_skid_buf).
package id2ex_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_OP_W       = 6;
    localparam int DEF_CNT_W      = 16;

    // Decode payload at the default widths.
    typedef struct packed {
        logic [DEF_OP_W-1:0]       opcode;
        logic [DEF_DATA_W-1:0]     rs_data;
        logic [DEF_DATA_W-1:0]     rt_data;
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0]     imm;
    } id2ex_payload_t;

    // EMPTY: no beat; FULL: main holds a beat; SKID: main and skid both hold beats.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Width of the flattened payload vector for arbitrary field widths.
    function automatic int payload_width(input int op_w, input int data_w, input int ra_w);
        return op_w + 3 * data_w + ra_w;
    endfunction

endpackage

// File: rtl/id2ex_pipe_reg_skid_buf.sv
// pipe_skid_buf: generic valid/ready pipeline slot with optional skid entry.
// Build option: ID2EX_SKID_EN adds the skid register and SKID state, making
// in_ready_o a pure register output. Without it in_ready_o depends
// combinationally on out_ready_i.
// Handshake: a beat moves when valid & ready are both high at a rising edge;
// a presented beat is never retracted and held data never changes while stalled.
module pipe_skid_buf
    import id2ex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   state_o
);

    pipe_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic         out_valid;
    logic         accept;
`ifdef ID2EX_SKID_EN
    logic [W-1:0] skid_q, skid_d;
`endif

    assign out_valid  = (state_q != EMPTY);
`ifdef ID2EX_SKID_EN
    assign in_ready_o = (state_q != SKID);
`else
    assign in_ready_o = !out_valid | out_ready_i;
`endif
    assign accept     = in_valid_i & in_ready_o;
    assign out_data_o = main_q;
    assign state_o    = state_q;

    // Next-state and payload steering; flush overrides everything and drops the input beat.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef ID2EX_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    main_d  = in_data_i;
                end
            end
            FULL: begin
                if (accept && out_ready_i) begin
                    main_d = in_data_i;
                end else if (accept) begin
`ifdef ID2EX_SKID_EN
                    state_d = SKID;
                    skid_d  = in_data_i;
`endif
                end else if (out_ready_i) begin
                    state_d = EMPTY;
                end
            end
`ifdef ID2EX_SKID_EN
            SKID: begin
                if (out_ready_i) begin
                    state_d = FULL;
                    main_d  = skid_q;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = main_q;
`ifdef ID2EX_SKID_EN
            skid_d  = skid_q;
`endif
        end
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef ID2EX_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef ID2EX_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: rtl/id2ex_pipe_reg.sv
// id2ex_pipe_reg: ID->EX pipeline register with valid/ready flow control,
// flush-to-bubble and a saturating stall counter.
// Build option: ID2EX_SKID_EN enables the skid slot inside pipe_skid_buf.
// stall_cnt counts cycles with out_valid=1 and out_ready=0; only reset clears it.
module id2ex_pipe_reg
    import id2ex_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int OP_W       = DEF_OP_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       opcode_in,
    input  logic [DATA_W-1:0]     rs_data_in,
    input  logic [DATA_W-1:0]     rt_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0]     imm_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_W-1:0]       opcode_out,
    output logic [DATA_W-1:0]     rs_data_out,
    output logic [DATA_W-1:0]     rt_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [DATA_W-1:0]     imm_out,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PW = payload_width(OP_W, DATA_W, REG_ADDR_W);

    logic [PW-1:0]    pl_in, pl_out;
    logic [1:0]       buf_state;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign pl_in = {opcode_in, rs_data_in, rt_data_in, rd_in, imm_in};

    pipe_skid_buf #(.W(PW)) u_buf (
        .clk_i      (clk),
        .rst_ni     (reset),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (pl_in),
        .out_ready_i(out_ready),
        .out_data_o (pl_out),
        .state_o    (buf_state)
    );

    assign {opcode_out, rs_data_out, rt_data_out, rd_out, imm_out} = pl_out;
    assign out_valid = (buf_state != EMPTY);
    assign stall     = out_valid & !out_ready;
    assign stall_cnt = stall_cnt_q;

    // Saturating increment on every stalled cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id2ex_pipe_reg.sv
// Directed bench for id2ex_pipe_reg (CNT_W=4 so saturation is reachable).
// Covers both builds: back-pressure/flush sequences branch on ID2EX_SKID_EN.
module tb_id2ex_pipe_reg;

    localparam int CNT_W = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode_in;
    logic [31:0] rs_data_in;
    logic [31:0] rt_data_in;
    logic [4:0]  rd_in;
    logic [31:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode_out;
    logic [31:0] rs_data_out;
    logic [31:0] rt_data_out;
    logic [4:0]  rd_out;
    logic [31:0] imm_out;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec;
    int n_err;

    id2ex_pipe_reg #(
        .DATA_W(32), .REG_ADDR_W(5), .OP_W(6), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
        .rd_in(rd_in), .imm_in(imm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode_out(opcode_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
        .rd_out(rd_out), .imm_out(imm_out),
        .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every field of a beat is derived from its opcode.
    task automatic drive_beat(input logic [5:0] op);
        in_valid   = 1'b1;
        opcode_in  = op;
        rs_data_in = 32'h1000_0000 + {26'd0, op};
        rt_data_in = 32'h2000_0000 + {26'd0, op};
        rd_in      = op[4:0];
        imm_in     = 32'hFFFF_0000 | {26'd0, op};
    endtask

    task automatic check_beat(input string tag, input logic [5:0] op);
        logic [4:0] exp_rd;
        exp_rd = op[4:0];
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".op"},    32'(opcode_out), 32'(op));
        check({tag, ".rs"},    rs_data_out, 32'h1000_0000 + {26'd0, op});
        check({tag, ".rt"},    rt_data_out, 32'h2000_0000 + {26'd0, op});
        check({tag, ".rd"},    32'(rd_out), 32'(exp_rd));
        check({tag, ".imm"},   imm_out, 32'hFFFF_0000 | {26'd0, op});
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_beat(6'($urandom_range(0, 63)));
        step();
        step();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive_beat(6'h00);

        // Reset held two cycles with a live input beat.
        do_reset();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.op",    32'(opcode_out), 32'd0);
        check("rst.rs",    rs_data_out, 32'd0);
        check("rst.rt",    rt_data_out, 32'd0);
        check("rst.rd",    32'(rd_out), 32'd0);
        check("rst.imm",   imm_out, 32'd0);
        check("rst.stall", 32'(stall_cnt), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Streaming at full rate.
        out_ready = 1'b1;
        drive_beat(6'h23); step(); check_beat("s0", 6'h23);
        drive_beat(6'h2B); step(); check_beat("s1", 6'h2B);
        drive_beat(6'h04); step(); check_beat("s2", 6'h04);
        in_valid = 1'b0;   step();
        check("s.drain", 32'(out_valid), 32'd0);
        check("s.stall", 32'(stall_cnt), 32'd0);

`ifdef ID2EX_SKID_EN
        // Back-pressure into the skid slot.
        out_ready = 1'b0;
        drive_beat(6'h11); step(); check_beat("bp.a", 6'h11);
        check("bp.rdy_full", 32'(in_ready), 32'd1);
        drive_beat(6'h12); step();
        check("bp.rdy_skid", 32'(in_ready), 32'd0);
        check_beat("bp.hold_a", 6'h11);
        check("bp.stall1", 32'(stall_cnt), 32'd1);
        in_valid = 1'b0;   step();
        check_beat("bp.hold_a2", 6'h11);
        check("bp.stall2", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;  step();
        check_beat("bp.b", 6'h12);
        check("bp.rdy_back", 32'(in_ready), 32'd1);
        step();
        check("bp.drain", 32'(out_valid), 32'd0);
        check("bp.stall", 32'(stall_cnt), 32'd2);

        // Flush while SKID holds A and B and C is presented.
        out_ready = 1'b0;
        drive_beat(6'h31); step();
        drive_beat(6'h32); step();
        check("fl.skid", 32'(in_ready), 32'd0);
        drive_beat(6'h33); flush = 1'b1; step();
        flush = 1'b0;
        check("fl.valid", 32'(out_valid), 32'd0);
        check("fl.stall", 32'(stall_cnt), 32'd4);
        in_valid = 1'b0; out_ready = 1'b1; step();
        check("fl.none", 32'(out_valid), 32'd0);
        check("fl.stall_keep", 32'(stall_cnt), 32'd4);
`else
        // Without skid, in_ready follows out_ready combinationally.
        out_ready = 1'b0;
        drive_beat(6'h11); step(); check_beat("bp.a", 6'h11);
        drive_beat(6'h12); #1;
        check("bp.rdy_low", 32'(in_ready), 32'd0);
        step();
        check_beat("bp.hold_a", 6'h11);
        check("bp.stall1", 32'(stall_cnt), 32'd1);
        out_ready = 1'b1; #1;
        check("bp.rdy_comb", 32'(in_ready), 32'd1);
        step();
        check_beat("bp.b", 6'h12);
        in_valid = 1'b0; step();
        check("bp.drain", 32'(out_valid), 32'd0);
        check("bp.stall", 32'(stall_cnt), 32'd1);

        // Flush with A held and B presented.
        out_ready = 1'b0;
        drive_beat(6'h31); step();
        drive_beat(6'h32); flush = 1'b1; step();
        flush = 1'b0;
        check("fl.valid", 32'(out_valid), 32'd0);
        check("fl.stall", 32'(stall_cnt), 32'd2);
        in_valid = 1'b0; out_ready = 1'b1; step();
        check("fl.none", 32'(out_valid), 32'd0);
        check("fl.stall_keep", 32'(stall_cnt), 32'd2);
`endif

        // Stage works normally after a flush.
        drive_beat(6'h3C); step(); check_beat("fl.after", 6'h3C);
        in_valid = 1'b0;   step();
        check("fl.after_drain", 32'(out_valid), 32'd0);

        // Saturation: one beat stalled for 20 cycles.
        do_reset();
        check("sat.rst", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0;
        drive_beat(6'h2A); step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) check("sat.mid", 32'(stall_cnt), 32'd10);
        end
        check("sat.max", 32'(stall_cnt), 32'd15);
        check_beat("sat.stable", 6'h2A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
